// File: rtl/pstats_pkg.sv
// Shared constants and types for the port-statistics event counter bank.
package pstats_pkg;
  localparam int c_PSTATS_EVENTS     = 10;
  localparam int c_PSTATS_CNT_WIDTH  = 32;
  localparam int c_PSTATS_ADDR_WIDTH = $clog2(c_PSTATS_EVENTS);

  typedef logic [c_PSTATS_CNT_WIDTH-1:0] t_pstats_cnt;
endpackage

// File: rtl/pstats_rr_arbiter.sv
// Round-robin first-set finder: returns the first pending index at or above ptr_i, wrapping.
module pstats_rr_arbiter
  import pstats_pkg::*;
#(
  parameter int g_events     = c_PSTATS_EVENTS,
  parameter int g_addr_width = $clog2(g_events)
) (
  input  logic [g_events-1:0]     pend_i,
  input  logic [g_addr_width-1:0] ptr_i,
  output logic [g_addr_width-1:0] sel_o,
  output logic                    valid_o
);

  logic [2*g_events-1:0] w_rot;

  // Duplicating the bitmap turns the wrap-around search into a plain low-to-high scan.
  assign w_rot = {pend_i, pend_i} >> ptr_i;

  always_comb begin
    int w_ofs;
    int w_sum;
    w_ofs   = 0;
    w_sum   = 0;
    valid_o = 1'b0;
    sel_o   = '0;
    for (int i = g_events - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_ofs   = i;
        valid_o = 1'b1;
      end
    end
    w_sum = int'(ptr_i) + w_ofs;
    if (w_sum >= g_events) w_sum = w_sum - g_events;
    if (valid_o) sel_o = g_addr_width'(w_sum);
  end

endmodule

// File: rtl/pstats_evt_counter.sv
// Per-port statistics counter bank with edge capture, round-robin increment and clear-on-read.
// Optional overflow interrupt enabled by defining PSTATS_CNT_OVF_IRQ_EN.
module pstats_evt_counter
  import pstats_pkg::*;
#(
  parameter int g_events     = c_PSTATS_EVENTS,
  parameter int g_cnt_width  = c_PSTATS_CNT_WIDTH,
  parameter int g_addr_width = $clog2(g_events)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [g_events-1:0]     trig_i,
  input  logic                    rd_req_i,
  input  logic [g_addr_width-1:0] rd_addr_i,
  input  logic                    rd_clr_i,
  output logic                    rd_ack_o,
  output logic [g_cnt_width-1:0]  rd_data_o,
  output logic                    drop_o,
  output logic                    irq_o
);

  logic [g_events-1:0]     r_trig_q, r_trig_q2, r_pend;
  logic [g_addr_width-1:0] r_ptr;
  logic [g_cnt_width-1:0]  r_cnt [g_events];
  logic                    r_ack, r_drop;
  logic [g_cnt_width-1:0]  r_data;

  logic [g_events-1:0]     w_edge, w_svc, w_clr;
  logic [g_addr_width-1:0] w_sel;
  logic                    w_valid, w_lost, w_rd_clr;
  logic [g_cnt_width-1:0]  w_rd_val;

  pstats_rr_arbiter #(
    .g_events    (g_events),
    .g_addr_width(g_addr_width)
  ) u_arb (
    .pend_i (r_pend),
    .ptr_i  (r_ptr),
    .sel_o  (w_sel),
    .valid_o(w_valid)
  );

  assign w_edge   = r_trig_q & ~r_trig_q2;
  assign w_rd_clr = rd_req_i & rd_clr_i;

  always_comb begin
    w_svc = '0;
    w_clr = '0;
    for (int n = 0; n < g_events; n++) begin
      w_svc[n] = w_valid && (int'(w_sel) == n);
      w_clr[n] = w_rd_clr && (int'(rd_addr_i) == n);
    end
  end

  // A new edge while the previous one is still waiting (and not being serviced now) is lost.
  assign w_lost   = |(w_edge & r_pend & ~w_svc);
  assign w_rd_val = (int'(rd_addr_i) < g_events) ? r_cnt[rd_addr_i] : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_trig_q  <= '0;
      r_trig_q2 <= '0;
      r_pend    <= '0;
      r_ptr     <= '0;
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_trig_q  <= trig_i;
      r_trig_q2 <= r_trig_q;
      r_pend    <= (r_pend & ~w_svc) | w_edge;
      if (w_valid) begin
        r_ptr <= (int'(w_sel) == g_events - 1) ? '0 : w_sel + g_addr_width'(1);
      end
      r_ack <= rd_req_i;
      if (rd_req_i) r_data <= w_rd_val;
      r_drop <= w_lost | (r_drop & ~w_rd_clr);
    end
  end

  // Clear-on-read racing a service of the same counter leaves 1, so no increment is lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < g_events; n++) r_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < g_events; n++) begin
        if (w_clr[n]) r_cnt[n] <= g_cnt_width'(w_svc[n]);
        else if (w_svc[n]) r_cnt[n] <= r_cnt[n] + g_cnt_width'(1);
      end
    end
  end

`ifdef PSTATS_CNT_OVF_IRQ_EN
  logic [g_events-1:0] r_ovf, w_wrap, w_ovf_nxt;
  logic                r_irq;

  always_comb begin
    w_wrap = '0;
    for (int n = 0; n < g_events; n++) begin
      w_wrap[n] = w_svc[n] && (r_cnt[n] == '1);
    end
  end

  assign w_ovf_nxt = w_wrap | (r_ovf & ~w_clr);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ovf <= w_ovf_nxt;
      r_irq <= |w_ovf_nxt;
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  assign rd_ack_o  = r_ack;
  assign rd_data_o = r_data;
  assign drop_o    = r_drop;

endmodule

// File: tb/tb_pstats_evt_counter.sv
// Randomized and directed bench for pstats_evt_counter against a behavioural event-count model.
module tb_pstats_evt_counter;
  localparam int N  = 10;
  localparam int CW = 4;
  localparam int AW = 4;
  localparam int M  = 1 << CW;

  logic          clk, rst_n;
  logic [N-1:0]  trig;
  logic          rd_req, rd_clr;
  logic [AW-1:0] rd_addr;
  logic          rd_ack, drop, irq;
  logic [CW-1:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_cnt [N];
  bit m_pend [N];
  bit m_ovf [N];
  bit m_h1 [N];
  bit m_h2 [N];
  int m_ptr;
  bit m_drop;
  bit e_ack;
  int e_data;
  bit e_irq;

  pstats_evt_counter #(
    .g_events    (N),
    .g_cnt_width (CW),
    .g_addr_width(AW)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .trig_i   (trig),
    .rd_req_i (rd_req),
    .rd_addr_i(rd_addr),
    .rd_clr_i (rd_clr),
    .rd_ack_o (rd_ack),
    .rd_data_o(rd_data),
    .drop_o   (drop),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_cnt[n] = 0; m_pend[n] = 0; m_ovf[n] = 0; m_h1[n] = 0; m_h2[n] = 0;
    end
    m_ptr = 0; m_drop = 0; e_ack = 0; e_data = 0; e_irq = 0;
  endtask

  // One clock of behaviour, using the inputs the DUT samples at this edge.
  task automatic model_step();
    int sel;
    bit lost, rclr, ev, svc, hit, wrap, any;
    sel  = -1;
    lost = 0;
    any  = 0;
    for (int k = 0; k < N; k++) begin
      if (sel < 0 && m_pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
    end
    e_ack = rd_req;
    if (rd_req) e_data = (int'(rd_addr) < N) ? m_cnt[rd_addr] : 0;
    rclr = rd_req && rd_clr;
    for (int n = 0; n < N; n++) begin
      ev   = m_h1[n] && !m_h2[n];
      svc  = (n == sel);
      hit  = rclr && (int'(rd_addr) == n);
      wrap = svc && (m_cnt[n] == M - 1);
      if (ev && m_pend[n] && !svc) lost = 1;
      if (hit) m_cnt[n] = svc ? 1 : 0;
      else if (svc) m_cnt[n] = (m_cnt[n] + 1) % M;
      m_ovf[n]  = wrap || (m_ovf[n] && !hit);
      m_pend[n] = ev || (m_pend[n] && !svc);
      m_h2[n]   = m_h1[n];
      m_h1[n]   = trig[n];
      any       = any | m_ovf[n];
    end
    if (sel >= 0) m_ptr = (sel + 1) % N;
    m_drop = lost || (m_drop && !rclr);
`ifdef PSTATS_CNT_OVF_IRQ_EN
    e_irq = any;
`else
    e_irq = 0;
`endif
  endtask

  task automatic check_outputs();
    check_eq("ack", int'(rd_ack), int'(e_ack));
    if (e_ack) check_eq("data", int'(rd_data), e_data);
    check_eq("drop", int'(drop), int'(m_drop));
    check_eq("irq", int'(irq), int'(e_irq));
  endtask

  task automatic tick(input logic [N-1:0] t, input logic rq, input logic [AW-1:0] a, input logic c);
    trig = t; rd_req = rq; rd_addr = a; rd_clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick('0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before any clock edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_ack"}, int'(rd_ack), 0);
    check_eq({tag, "_data"}, int'(rd_data), 0);
    check_eq({tag, "_drop"}, int'(drop), 0);
    check_eq({tag, "_irq"}, int'(irq), 0);
    trig = '0; rd_req = 1'b0; rd_addr = '0; rd_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_const(input string tag, input int a, input bit c, input int exp);
    tick('0, 1'b1, AW'(a), c);
    check_eq({tag, "_ack"}, int'(rd_ack), 1);
    check_eq(tag, int'(rd_data), exp);
  endtask

  initial begin
    logic [N-1:0] t;
    rst_n = 1'b1; trig = '0; rd_req = 1'b0; rd_addr = '0; rd_clr = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // single pulse on line 3
    tick(N'(1 << 3), 1'b0, '0, 1'b0);
    idle(3);
    for (int a = 0; a < N; a++) read_const("tp1_cnt", a, 1'b0, (a == 3) ? 1 : 0);
    read_const("tp1_oob", 12, 1'b0, 0);

    // all lines together
    do_reset("rst1");
    tick('1, 1'b0, '0, 1'b0);
    tick('0, 1'b0, '0, 1'b0);
    idle(N);
    for (int a = 0; a < N; a++) read_const("tp2_cnt", a, 1'b0, 1);
    check_eq("tp2_drop", int'(drop), 0);

    // clear-on-read racing a service, prior value 7
    do_reset("rst2");
    for (int i = 0; i < 7; i++) begin
      tick(N'(1 << 2), 1'b0, '0, 1'b0);
      tick('0, 1'b0, '0, 1'b0);
    end
    idle(3);
    tick(N'(1 << 2), 1'b0, '0, 1'b0);
    tick('0, 1'b0, '0, 1'b0);
    read_const("tp4_race", 2, 1'b1, 7);
    read_const("tp4_after", 2, 1'b0, 1);

    // 16 edges on line 1 wrap a 4-bit counter
    do_reset("rst3");
    for (int i = 0; i < 16; i++) begin
      tick(N'(1 << 1), 1'b0, '0, 1'b0);
      tick('0, 1'b0, '0, 1'b0);
    end
    idle(3);
`ifdef PSTATS_CNT_OVF_IRQ_EN
    check_eq("tp5_irq", int'(irq), 1);
`else
    check_eq("tp5_irq", int'(irq), 0);
`endif
    read_const("tp5_cnt", 1, 1'b0, 0);
    read_const("tp5_clr", 1, 1'b1, 0);
    tick('0, 1'b0, '0, 1'b0);
    check_eq("tp5_irq_clr", int'(irq), 0);

    // overload: line 5 every 2 cycles, the rest toggling too
    do_reset("rst4");
    for (int i = 0; i < 20; i++) tick((i % 2 == 0) ? '1 : '0, 1'b0, '0, 1'b0);
    idle(N + 2);
    check_eq("tp3_drop", int'(drop), 1);
    tick('0, 1'b1, AW'(5), 1'b0);
    check_eq("tp3_cnt5_lt", int'(int'(rd_data) < 10), 1);

    // randomized traffic
    do_reset("rst5");
    for (int i = 0; i < 3000; i++) begin
      t = N'($urandom) & N'($urandom) & N'($urandom);
      tick(t, 1'($urandom_range(0, 9) < 3), AW'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0));
      if (i == 1500) begin
        tick('1, 1'b1, AW'(4), 1'b0);
        do_reset("rst_mid");
        for (int a = 0; a < N; a++) read_const("rst_mid_cnt", a, 1'b0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
